// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of ram_port_arbiter: level req / one-cycle ack handshake for three ports
// plus the shared read-data, grant and busy status returned to all of them.
interface ram_port_arbiter_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 11
);
  logic [2:0]           req;
  logic [2:0]           we;
  logic [ADDR_BITS-1:0] addr0;
  logic [ADDR_BITS-1:0] addr1;
  logic [ADDR_BITS-1:0] addr2;
  logic [DATA_BITS-1:0] wdata0;
  logic [DATA_BITS-1:0] wdata1;
  logic [DATA_BITS-1:0] wdata2;
  logic [2:0]           ack;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           grant;
  logic                 busy;

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    input  ack, rdata, grant, busy
  );

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    output ack, rdata, grant, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between CPU (0), video (1) and DMA (2) via an IDLE/ACCESS/DONE FSM.
// Define RAM_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority 0 > 1 > 2.
module ram_port_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_port_arbiter_if.slave    bus,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_nwe,
  output logic [DATA_BITS-1:0] ram_din,
  input  logic [DATA_BITS-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'd3;

  state_t               state_q, state_d;
  logic [2:0]           ack_q, ack_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic [1:0]           grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic                 ram_nwe_q, ram_nwe_d;
  logic [DATA_BITS-1:0] ram_din_q, ram_din_d;
  logic                 wr_q, wr_d;

  logic                 win_valid;
  logic [1:0]           win_idx;
  logic [ADDR_BITS-1:0] win_addr;
  logic [DATA_BITS-1:0] win_wdata;
  logic                 win_we;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // last_q holds the most recently served port; search starts one past it.
  logic [1:0] last_q, last_d;
  logic [1:0] cand [3];
  logic [2:0] hit;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum      = {1'b0, last_q} + 3'(gi + 1);
    assign cand[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign hit[gi]  = (cand[gi] == 2'd0) ? bus.req[0] :
                      (cand[gi] == 2'd1) ? bus.req[1] : bus.req[2];
  end

  always_comb begin
    win_valid = |hit;
    if (hit[0]) begin
      win_idx = cand[0];
    end else if (hit[1]) begin
      win_idx = cand[1];
    end else begin
      win_idx = cand[2];
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == DONE) begin
      last_d = grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 2'd2;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    win_valid = |bus.req;
    if (bus.req[0]) begin
      win_idx = 2'd0;
    end else if (bus.req[1]) begin
      win_idx = 2'd1;
    end else begin
      win_idx = 2'd2;
    end
  end
`endif

  always_comb begin
    win_addr  = bus.addr0;
    win_wdata = bus.wdata0;
    win_we    = bus.we[0];
    case (win_idx)
      2'd1: begin
        win_addr  = bus.addr1;
        win_wdata = bus.wdata1;
        win_we    = bus.we[1];
      end
      2'd2: begin
        win_addr  = bus.addr2;
        win_wdata = bus.wdata2;
        win_we    = bus.we[2];
      end
      default: ;
    endcase
  end

  // ram_nwe defaults high so a write strobe can only last the single ACCESS cycle.
  always_comb begin
    state_d    = state_q;
    ack_d      = 3'b000;
    rdata_d    = rdata_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_nwe_d  = 1'b1;
    wr_d       = wr_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          ram_addr_d = win_addr;
          ram_din_d  = win_wdata;
          ram_nwe_d  = ~win_we;
          wr_d       = win_we;
          grant_d    = win_idx;
          busy_d     = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DONE;
      end
      DONE: begin
        if (!wr_q) begin
          rdata_d = ram_dout;
        end
        ack_d   = 3'b001 << grant_q;
        grant_d = GRANT_NONE;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= 3'b000;
      rdata_q    <= '0;
      grant_q    <= GRANT_NONE;
      busy_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_nwe_q  <= 1'b1;
      ram_din_q  <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      ram_addr_q <= ram_addr_d;
      ram_nwe_q  <= ram_nwe_d;
      ram_din_q  <= ram_din_d;
      wr_q       <= wr_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign ram_addr  = ram_addr_q;
  assign ram_nwe   = ram_nwe_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-schedule reference model; honours RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic [10:0] ram_addr;
  logic        ram_nwe;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  int          vectors;
  int          miscompares;
  int          cyc;

  ram_port_arbiter_if #(.DATA_BITS(8), .ADDR_BITS(11)) bif ();

  ram_port_arbiter #(.DATA_BITS(8), .ADDR_BITS(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bif),
    .ram_addr (ram_addr),
    .ram_nwe  (ram_nwe),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Single-port synchronous RAM with registered read.
  logic [7:0] ram_mem [2048];
  always @(posedge clk) begin
    if (!ram_nwe) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [10:0] a, input logic [7:0] d);
    bif.req[p] = r;
    bif.we[p]  = w;
    case (p)
      0: begin bif.addr0 = a; bif.wdata0 = d; end
      1: begin bif.addr1 = a; bif.wdata1 = d; end
      default: begin bif.addr2 = a; bif.wdata2 = d; end
    endcase
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bif.req = 3'b000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (bif.rdata !== 8'h00 || ram_addr !== 11'h000 || ram_din !== 8'h00) begin
      $display("FAIL reset_values rdata=%h ram_addr=%h ram_din=%h required 00/000/00",
               bif.rdata, ram_addr, ram_din);
      miscompares++;
    end
    vectors++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_nwe !== 1'b1 || bif.ack !== 3'b000 || bif.grant !== 2'd3 || bif.busy !== 1'b0) begin
        $display("FAIL reset_idle cyc=%0d nwe=%b ack=%b grant=%0d busy=%b required 1/000/3/0",
                 i, ram_nwe, bif.ack, bif.grant, bif.busy);
        miscompares++;
      end
      vectors++;
    end
    $display("test_reset: idle after reset checked for 10 cycles");
  endtask

  task automatic test_random();
    int          n = 0;
    int          g_edge = -100;
    int          next_eval = 0;
    int          m_last = 2;
    int          w;
    int          served = 0;
    logic [1:0]  cur = 2'd0;
    logic        cur_we = 1'b0;
    logic [10:0] cur_addr = '0;
    logic [7:0]  cur_wdata = '0;
    logic [7:0]  exp_read = '0;
    logic [7:0]  exp_rdata = 8'h00;
    logic [7:0]  ref_mem [64];
    logic [63:0] ref_known = '0;
    logic [2:0]  pend = 3'b000;
    logic [2:0]  req_s, we_s, exp_ack;
    logic [10:0] a_s [3];
    logic [7:0]  d_s [3];
    logic        in_busy;
    logic [5:0]  ra;

    for (int c = 0; c < 900; c++) begin
      req_s = bif.req;
      we_s  = bif.we;
      a_s[0] = bif.addr0; a_s[1] = bif.addr1; a_s[2] = bif.addr2;
      d_s[0] = bif.wdata0; d_s[1] = bif.wdata1; d_s[2] = bif.wdata2;
      tick();
      n++;
      // Reference: a free arbiter takes a pending request and is busy for three edges.
      if (n >= next_eval && req_s != 3'b000) begin
        w = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        for (int k = 3; k >= 1; k--) begin
          if (req_s[(m_last + k) % 3]) w = (m_last + k) % 3;
        end
`else
        for (int k = 2; k >= 0; k--) begin
          if (req_s[k]) w = k;
        end
`endif
        m_last    = w;
        g_edge    = n;
        next_eval = n + 3;
        cur       = 2'(w);
        cur_we    = we_s[w];
        cur_addr  = a_s[w];
        cur_wdata = d_s[w];
        if (cur_we) begin
          ref_mem[cur_addr[5:0]]   = cur_wdata;
          ref_known[cur_addr[5:0]] = 1'b1;
        end else begin
          exp_read = ref_mem[cur_addr[5:0]];
        end
      end
      exp_ack = (n == g_edge + 2) ? (3'b001 << cur) : 3'b000;
      in_busy = (n == g_edge) || (n == g_edge + 1);
      if (n == g_edge + 2 && !cur_we) exp_rdata = exp_read;

      if (bif.ack !== exp_ack || bif.busy !== in_busy ||
          bif.grant !== (in_busy ? cur : 2'd3) ||
          ram_nwe !== !(n == g_edge && cur_we) || bif.rdata !== exp_rdata) begin
        $display("FAIL random_cycle n=%0d ack=%b grant=%0d busy=%b nwe=%b rdata=%h required %b/%0d/%b/%b/%h",
                 n, bif.ack, bif.grant, bif.busy, ram_nwe, bif.rdata, exp_ack,
                 in_busy ? cur : 2'd3, in_busy, !(n == g_edge && cur_we), exp_rdata);
        miscompares++;
      end
      vectors++;
      if (in_busy) begin
        if (ram_addr !== cur_addr || ram_din !== cur_wdata) begin
          $display("FAIL random_ram_bus n=%0d ram_addr=%h ram_din=%h required %h/%h",
                   n, ram_addr, ram_din, cur_addr, cur_wdata);
          miscompares++;
        end
        vectors++;
      end
      if (exp_ack != 3'b000) served++;

      // Requesters: drop on ack, otherwise occasionally raise a new access.
      for (int p = 0; p < 3; p++) begin
        if (bif.ack[p]) begin
          pend[p] = 1'b0;
          set_port(p, 1'b0, 1'b0, 11'($urandom), 8'($urandom));
        end else if (!pend[p]) begin
          if ($urandom_range(0, 3) == 0) begin
            ra = 6'($urandom);
            pend[p] = 1'b1;
            if (!ref_known[ra] || $urandom_range(0, 1) == 0)
              set_port(p, 1'b1, 1'b1, {5'b0, ra}, 8'($urandom));
            else
              set_port(p, 1'b1, 1'b0, {5'b0, ra}, 8'($urandom));
          end else begin
            set_port(p, 1'b0, 1'($urandom), 11'($urandom), 8'($urandom));
          end
        end
      end
    end
    bif.req = 3'b000;
    tick();
    tick();
    tick();
    $display("test_random: %0d accesses completed over %0d cycles", served, n);
  endtask

  task automatic test_write_read();
    logic [2:0] exp_ack;
    int nwe_low = 0;
    tick();
    set_port(1, 1'b1, 1'b1, 11'h123, 8'hA5);
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (ram_nwe === 1'b0) nwe_low++;
      if (e == 1 && (bif.grant !== 2'd1 || bif.busy !== 1'b1 || ram_addr !== 11'h123 || ram_din !== 8'hA5)) begin
        $display("FAIL wr_grant grant=%0d busy=%b addr=%h din=%h required 1/1/123/a5",
                 bif.grant, bif.busy, ram_addr, ram_din);
        miscompares++;
      end
      exp_ack = (e == 3) ? 3'b010 : 3'b000;
      if (bif.ack !== exp_ack) begin
        $display("FAIL wr_ack edge=%0d ack=%b required %b", e, bif.ack, exp_ack);
        miscompares++;
      end
      vectors++;
    end
    set_port(1, 1'b0, 1'b0, 11'h000, 8'h00);
    tick();
    if (ram_nwe === 1'b0) nwe_low++;
    if (nwe_low != 1) begin
      $display("FAIL wr_nwe_pulse low_cycles=%0d required 1", nwe_low);
      miscompares++;
    end
    vectors++;
    set_port(1, 1'b1, 1'b0, 11'h123, 8'h00);
    tick();
    tick();
    tick();
    if (bif.ack !== 3'b010 || bif.rdata !== 8'hA5) begin
      $display("FAIL rd_back ack=%b rdata=%h required 010/a5", bif.ack, bif.rdata);
      miscompares++;
    end
    vectors++;
    set_port(1, 1'b0, 1'b0, 11'h000, 8'h00);
    tick();
    $display("test_write_read: port 1 write 0x123=a5 then read back");
  endtask

  task automatic test_two_ports();
    int t0 = -1;
    int t2 = -1;
    set_port(0, 1'b1, 1'b0, 11'h123, 8'h00);
    set_port(2, 1'b1, 1'b0, 11'h123, 8'h00);
    tick();
    if (bif.grant !== 2'd0) begin
      $display("FAIL two_first_grant grant=%0d required 0", bif.grant);
      miscompares++;
    end
    vectors++;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (bif.ack[0] === 1'b1) begin
        t0 = cyc;
        set_port(0, 1'b0, 1'b0, 11'h000, 8'h00);
      end
      if (bif.ack[2] === 1'b1) begin
        t2 = cyc;
        set_port(2, 1'b0, 1'b0, 11'h000, 8'h00);
        if (t0 < 0) begin
          $display("FAIL two_order port2 acked before port0");
          miscompares++;
        end
        vectors++;
      end
      if (t0 >= 0 && cyc == t0 + 1 && bif.grant !== 2'd2) begin
        $display("FAIL two_second_grant grant=%0d required 2", bif.grant);
        miscompares++;
      end
    end
    if (t0 < 0 || t2 < 0 || t2 - t0 != 3) begin
      $display("FAIL two_spacing ack0_cyc=%0d ack2_cyc=%0d required 3 apart", t0, t2);
      miscompares++;
    end
    vectors++;
    if (bif.rdata !== 8'hA5) begin
      $display("FAIL two_rdata rdata=%h required a5", bif.rdata);
      miscompares++;
    end
    vectors++;
    bif.req = 3'b000;
    tick();
    $display("test_two_ports: ack0 at %0d, ack2 at %0d", t0, t2);
  endtask

  task automatic test_all_three();
    int got;
    int expd;
    int waited;
    do_reset();
    set_port(0, 1'b1, 1'b0, 11'h123, 8'h00);
    set_port(1, 1'b1, 1'b0, 11'h123, 8'h00);
    set_port(2, 1'b1, 1'b0, 11'h123, 8'h00);
    for (int k = 0; k < 9; k++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (bif.ack === 3'b000 && waited < 6);
      case (bif.ack)
        3'b001:  got = 0;
        3'b010:  got = 1;
        3'b100:  got = 2;
        default: got = -1;
      endcase
`ifdef RAM_ARB_ROUND_ROBIN_EN
      expd = k % 3;
`else
      expd = 0;
`endif
      if (got != expd) begin
        $display("FAIL all_three_order access=%0d served=%0d ack=%b required port %0d",
                 k, got, bif.ack, expd);
        miscompares++;
      end
      vectors++;
    end
    bif.req = 3'b000;
    tick();
    tick();
    tick();
    $display("test_all_three: 9 accesses with all ports requesting");
  endtask

  task automatic test_reset_mid();
    set_port(2, 1'b1, 1'b1, 11'h7FF, 8'h5A);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_port(2, 1'b0, 1'b0, 11'h000, 8'h00);
    if (bif.ack !== 3'b000 || bif.grant !== 2'd3 || bif.busy !== 1'b0 ||
        ram_nwe !== 1'b1 || bif.rdata !== 8'h00 || ram_addr !== 11'h000) begin
      $display("FAIL midreset_outputs ack=%b grant=%0d busy=%b nwe=%b rdata=%h addr=%h required reset values",
               bif.ack, bif.grant, bif.busy, ram_nwe, bif.rdata, ram_addr);
      miscompares++;
    end
    vectors++;
    set_port(2, 1'b1, 1'b0, 11'h7FF, 8'h00);
    tick();
    if (bif.ack !== 3'b000 || bif.grant !== 2'd2 || bif.busy !== 1'b1) begin
      $display("FAIL midreset_idle ack=%b grant=%0d busy=%b required 000/2/1",
               bif.ack, bif.grant, bif.busy);
      miscompares++;
    end
    vectors++;
    tick();
    tick();
    if (bif.ack !== 3'b100 || bif.rdata !== 8'h5A) begin
      $display("FAIL midreset_readback ack=%b rdata=%h required 100/5a", bif.ack, bif.rdata);
      miscompares++;
    end
    vectors++;
    set_port(2, 1'b0, 1'b0, 11'h000, 8'h00);
    tick();
    $display("test_reset_mid: abandoned write to 0x7ff read back");
  endtask

  task automatic test_drop_after_grant();
    int acks = 0;
    set_port(0, 1'b1, 1'b0, 11'h7FF, 8'h00);
    tick();
    set_port(0, 1'b0, 1'b0, 11'h000, 8'h00);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bif.ack[0] === 1'b1) begin
        acks++;
        if (bif.rdata !== 8'h5A || i != 1) begin
          $display("FAIL drop_ack edge=%0d rdata=%h required edge 1 rdata 5a", i, bif.rdata);
          miscompares++;
        end
        vectors++;
      end
      if (i > 1 && (bif.busy !== 1'b0 || bif.grant !== 2'd3)) begin
        $display("FAIL drop_no_second busy=%b grant=%0d required 0/3", bif.busy, bif.grant);
        miscompares++;
      end
    end
    if (acks != 1) begin
      $display("FAIL drop_ack_count acks=%0d required 1", acks);
      miscompares++;
    end
    vectors++;
    $display("test_drop_after_grant: port 0 access completed after req dropped");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    bif.req     = 3'b000;
    bif.we      = 3'b000;
    bif.addr0   = '0; bif.addr1 = '0; bif.addr2 = '0;
    bif.wdata0  = '0; bif.wdata1 = '0; bif.wdata2 = '0;
    test_reset();
    test_random();
    test_write_read();
    test_two_ports();
    test_all_three();
    test_reset_mid();
    test_drop_after_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM between three requesters: CPU (port 0), video fetch (port 1) and DMA/copy engine (port 2).
- Each port runs a level request / one-cycle acknowledge handshake.
- The block sequences every access through a 3-state FSM and drives registered address, write-enable and data to the RAM.
- It sits between the bus decoders and the work/palette RAM instances.

Parameters:
DATA_BITS, 8, RAM word width
ADDR_BITS, 11, RAM address width

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
req  in  3  per-port access request, level; bit n = port n
we  in  3  per-port write flag, sampled with the grant
addr0/addr1/addr2  in  ADDR_BITS each  per-port address
wdata0/wdata1/wdata2  in  DATA_BITS each  per-port write data
ack  out  3  per-port one-cycle completion pulse
rdata  out  DATA_BITS  read data, valid in the ack cycle (shared by all ports)
grant  out  2  index of the port being served; 3 = none
busy  out  1  high while the FSM is not IDLE
ram_addr  out  ADDR_BITS  to RAM
ram_nwe  out  1  RAM write enable, active low
ram_din  out  DATA_BITS  to RAM
ram_dout  in  DATA_BITS  from RAM; registered, valid the cycle after the RAM samples ram_addr

Behaviour:
- Reset values: ack=0, rdata=0, grant=3, busy=0, ram_addr=0, ram_nwe=1, ram_din=0, state=IDLE.
- All outputs are registered.
- IDLE:
  - If any req bit is high at edge E0, select a winner per the priority rule.
  - Latch the winner's addr, wdata and we into ram_addr, ram_din and ram_nwe (ram_nwe = ~we).
  - Set grant=winner, busy=1, go to ACCESS.
  - With no request, stay in IDLE and hold ram_nwe=1.
- ACCESS (edge E1):
  - The RAM samples ram_addr/ram_din/ram_nwe at this edge.
  - Set ram_nwe=1 and go to DONE.
  - ram_nwe is therefore low for exactly one cycle per write.
- DONE (edge E2):
  - rdata <= ram_dout for reads; rdata holds its previous value for writes.
  - ack[grant] <= 1 for one cycle; grant <= 3; busy <= 0; go to IDLE.
- Timing: ack is high in the cycle after E2, i.e. 3 edges after req was sampled.
  - Sustained throughput is one access per 3 clocks.
- Requester rule: req must drop in the ack cycle. A req still high at the next IDLE evaluation is treated as a new request.
  - A requester that drops req before grant is simply not served.
  - Once granted, an access completes regardless of req.
- Priority (default): fixed, port 0 > port 1 > port 2.
- Simultaneous requests: exactly one winner; losers keep req high and are evaluated again in the next IDLE cycle.
- Address and data inputs of non-granted ports are ignored.
- Reset mid-operation:
  - Return to IDLE with all outputs at reset values on that edge; the access is abandoned and no ack is issued.
  - A write whose ram_nwe was already low in ACCESS is captured by the RAM at that same edge. This is accepted behaviour.
- Never more than one ack bit high at a time.
- ack never coincides with ram_nwe=0.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - A 2-bit last-winner register (reset = 2) is updated in DONE.
  - Search order starts at last_winner+1, mod 3.
  - Example: with all three requesting continuously, service order is 0,1,2,0,1,2.
- Undefined: fixed priority 0 > 1 > 2. The last-winner register is not built.

Test Plan:
- Reset then idle 10 cycles -> ram_nwe=1, ack=0, grant=3, busy=0 throughout.
- Port 1 write addr=0x123, wdata=0xA5, then port 1 read addr=0x123:
  - write: ram_nwe low exactly 1 cycle, ack[1] 3 edges after req;
  - read: ack[1] with rdata=0xA5.
- Ports 0 and 2 request reads in the same cycle -> port 0 acked first; port 2 granted in the following IDLE; acks 3 cycles apart.
- All three hold req for 9 accesses:
  - default: only port 0 is served;
  - with RAM_ARB_ROUND_ROBIN_EN: grant order 0,1,2,0,1,2,0,1,2.
- Port 2 write 0x5A to 0x7FF, reset asserted in the DONE cycle -> no ack[2]; FSM in IDLE next cycle; later read of 0x7FF returns 0x5A (write already committed).
- Port 0 drops req one cycle after IDLE grant -> access still completes with ack[0]; no second access issued.
